// File: rtl/msg_stream_pkg.sv
// Shared types and constants for the decoded-message UART streamer.
// Optional build macro: MSG_UART_STREAMER_PARITY_EN (adds even parity, 8E1 framing).
package msg_stream_pkg;

  localparam int DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef MSG_UART_STREAMER_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP,
    FIN
  } state_t;

  // Full serial frame, LSB transmitted first: start, data LSB..MSB, [parity], stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
`ifdef MSG_UART_STREAMER_PARITY_EN
    return {STOP_LVL, ^d, d, START_LVL};
`else
    return {STOP_LVL, d, START_LVL};
`endif
  endfunction

endpackage

// File: rtl/msg_uart_streamer_if.sv
// Synchronous RAM read port used by the message streamer (second port of data RAM).
interface msg_uart_streamer_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/msg_uart_tx_bit.sv
// Bit-period timer and frame shift register for the UART transmitter.
// tx is the LSB of a register, so the line never glitches.
// Optional build macro: MSG_UART_STREAMER_PARITY_EN (frame width via package).
module msg_uart_tx_bit
  import msg_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 run,
  output logic                 tx,
  output logic                 bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      cnt;

  // Load a whole frame, then shift one bit out per bit period while running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr  <= '1;
      cnt <= '0;
    end else if (load) begin
      sr  <= build_frame(din);
      cnt <= '0;
    end else if (run) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        sr  <= {IDLE_LVL, sr[FRAME_BITS-1:1]};
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // cnt rests at 0 when idle and CLKS_PER_BIT >= 2, so no spurious bit_done.
  assign tx       = sr[0];
  assign bit_done = (cnt == CNT_LAST);

endmodule

// File: rtl/msg_uart_streamer.sv
// Reads a run of characters (one per 32-bit RAM word) and streams bits [7:0]
// of each word out on a UART TX line, then pulses done.
// Optional build macro: MSG_UART_STREAMER_PARITY_EN (8E1 instead of 8N1).
module msg_uart_streamer
  import msg_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  msg_uart_streamer_if.master mem,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [2:0]        bit_idx;

  logic              ld;
  logic              run;
  logic              bit_done;
  logic [23:0]       unused_rdata_hi;

  assign unused_rdata_hi = mem.mem_rdata[31:8];
  assign mem.mem_addr    = addr;
  assign run = (state == START) || (state == DATA) ||
               (state == PARITY) || (state == STOP);

  // State register plus address, remaining-count and data-bit counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          bit_idx <= '0;
          if (start && (length != '0)) begin
            addr      <= base_addr;
            remaining <= length;
          end
        end
        DATA: begin
          if (bit_done) bit_idx <= bit_idx + 3'd1;
        end
        STOP: begin
          if (bit_done) begin
            remaining <= remaining - LEN_W'(1);
            addr      <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_n    = state;
    ld         = 1'b0;
    mem.mem_re = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_n = (length != '0) ? FETCH : FIN;
      end
      FETCH: begin
        mem.mem_re = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        ld      = 1'b1;
        state_n = START;
      end
      START: begin
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'(DATA_BITS - 1))) begin
`ifdef MSG_UART_STREAMER_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: begin
        if (bit_done) state_n = STOP;
      end
      STOP: begin
        if (bit_done) state_n = (remaining == LEN_W'(1)) ? FIN : FETCH;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  msg_uart_tx_bit #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_bit (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .din     (mem.mem_rdata[7:0]),
    .run     (run),
    .tx      (tx),
    .bit_done(bit_done)
  );

endmodule

// File: tb/tb_msg_uart_streamer.sv
// Directed bench for msg_uart_streamer with CLKS_PER_BIT=4.
// Optional build macro: MSG_UART_STREAMER_PARITY_EN (expects 8E1 frames).
module tb_msg_uart_streamer;

  localparam int CPB = 4;
`ifdef MSG_UART_STREAMER_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [7:0] length = '0;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [31:0]   ram [0:1023];
  logic [7:0]    exp_bytes [$];
  logic [FB-1:0] cap_bits;

  msg_uart_streamer_if #(.ADDR_W(10)) bus ();

  msg_uart_streamer #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (10),
    .LEN_W       (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .mem      (bus),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // RAM model: read data valid the cycle after mem_re.
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef MSG_UART_STREAMER_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse in cycle 0. Each character occupies P = FB*CPB + 2 cycles:
  // FETCH, WAIT, then FB bits of CPB cycles. done in cycle E, busy low at E+1.
  task automatic run_msg(input string tag, input logic [9:0] base,
                         input logic [7:0] len, input int inj_cycle);
    int P;
    int E;
    int f;
    int p;
    logic [FB-1:0] fr;
    logic [9:0] ea;
    logic e_tx, e_re, e_busy, e_done;
    P = FB * CPB + 2;
    E = 1 + int'(len) * P;
    start = 1'b1;
    base_addr = base;
    length = len;
    cap_bits = '0;
    for (int c = 1; c <= E + 2; c++) begin
      tick();
      start = 1'b0;
      base_addr = '0;
      length = '0;
      if (c == inj_cycle) begin
        start = 1'b1;
        base_addr = 10'h100;
        length = 8'd5;
      end
      e_tx = 1'b1;
      e_re = 1'b0;
      e_busy = (c <= E);
      e_done = (c == E);
      if (c < E) begin
        f = (c - 1) / P;
        p = (c - 1) % P;
        if (p == 0) begin
          e_re = 1'b1;
          ea = base + 10'(f);
          chk($sformatf("%s c%0d addr", tag, c), 32'(bus.mem_addr), 32'(ea));
        end else if (p >= 2) begin
          fr = frame_of(exp_bytes[f]);
          e_tx = fr[(p - 2) / CPB];
          if (f == 0 && ((p - 2) % CPB) == 2) cap_bits[(p - 2) / CPB] = tx;
        end
      end
      chk($sformatf("%s c%0d tx", tag, c), 32'(tx), 32'(e_tx));
      chk($sformatf("%s c%0d re", tag, c), 32'(bus.mem_re), 32'(e_re));
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(e_busy));
      chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(e_done));
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD_0000 + 32'(i);
    ram[10'h010] = 32'h0000_0041;
    ram[10'h3FE] = 32'hFFFF_FF48;
    ram[10'h3FF] = 32'h1234_566F;
    ram[10'h000] = 32'h8000_006C;
    ram[10'h001] = 32'h0000_7F61;
    ram[10'h020] = 32'h0000_0043;
    ram[10'h021] = 32'hABCD_EFA5;

    // Power-on reset
    rst = 1'b0;
    repeat (3) tick();
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst re", 32'(bus.mem_re), 32'd0);
    chk("rst addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b1;
    tick();

    // Single character 'A'
    exp_bytes = {8'h41};
    run_msg("one", 10'h010, 8'd1, 0);
`ifdef MSG_UART_STREAMER_PARITY_EN
    chk("bits41", 32'(cap_bits), 32'(11'b10010000010));
`else
    chk("bits41", 32'(cap_bits), 32'(10'b1010000010));
`endif

    // Four characters across the address wrap
    exp_bytes = {8'h48, 8'h6F, 8'h6C, 8'h61};
    run_msg("wrap", 10'h3FE, 8'd4, 0);

    // Zero length
    exp_bytes = {};
    run_msg("zero", 10'h155, 8'd0, 0);

    // Second start in the middle of the first frame must be ignored
    exp_bytes = {8'h43, 8'hA5};
    run_msg("ign", 10'h020, 8'd2, 20);
`ifdef MSG_UART_STREAMER_PARITY_EN
    chk("bits43", 32'(cap_bits), 32'(11'b11010000110));
`else
    chk("bits43", 32'(cap_bits), 32'(10'b1010000110));
`endif

    // Reset in the middle of DATA (cycle 15 carries data bit 2 of 0x41 = 0)
    start = 1'b1;
    base_addr = 10'h010;
    length = 8'd1;
    tick();
    start = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (14) tick();
    chk("mid tx", 32'(tx), 32'd0);
    chk("mid busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort re", 32'(bus.mem_re), 32'd0);
    chk("abort addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("post c%0d tx", c), 32'(tx), 32'd1);
      chk($sformatf("post c%0d busy", c), 32'(busy), 32'd0);
      chk($sformatf("post c%0d done", c), 32'(done), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
